// File: rtl/training_data_feeder.sv
// Responder side of the KNN calculator ready/data_request/done handshake: streams preloaded
// samples in MAX_ELEMENTS chunks. Define FEEDER_PROTOCOL_CHECK_EN to build the sticky protocol_err check.
module training_data_feeder #(
   parameter int M            = 4,
   parameter int N            = 4,
   parameter int W            = 16,
   parameter int MAX_ELEMENTS = 8,
   parameter int TYPE_W       = 2,
   parameter int NUM_SAMPLES  = 4
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               start,
   input  logic                                               wr_en,
   input  logic [$clog2(NUM_SAMPLES*M*N)-1:0]                 wr_addr,
   input  logic [W-1:0]                                       wr_data,
   input  logic                                               type_wr_en,
   input  logic [(NUM_SAMPLES > 1 ? $clog2(NUM_SAMPLES) : 1)-1:0] type_wr_addr,
   input  logic [TYPE_W-1:0]                                  type_wr_data,
   input  logic                                               data_request,
   input  logic                                               done,
   output logic [W*M*N-1:0]                                   training_data,
   output logic [TYPE_W-1:0]                                  training_data_type,
   output logic                                               ready,
   output logic [(NUM_SAMPLES > 1 ? $clog2(NUM_SAMPLES) : 1)-1:0] sample_idx,
   output logic                                               busy,
   output logic                                               all_done,
   output logic                                               protocol_err
);

   localparam int MN     = M * N;
   localparam int DEPTH  = NUM_SAMPLES * MN;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int IDX_W  = NUM_SAMPLES > 1 ? $clog2(NUM_SAMPLES) : 1;
   localparam int PTR_W  = $clog2(MN + 1);
   localparam int SLOT_W = MAX_ELEMENTS > 1 ? $clog2(MAX_ELEMENTS) : 1;

   typedef enum logic [2:0] {IDLE, FILL, PRESENT, WAIT, FINISH} state_t;
   state_t state, state_nx;

   logic [W-1:0]      elem_mem [DEPTH];
   logic [TYPE_W-1:0] type_mem [NUM_SAMPLES];
   logic [PTR_W-1:0]  elem_ptr;
   logic [SLOT_W-1:0] slot;
   logic [ADDR_W-1:0] rd_addr;
   logic              last_sample;
   logic              chunk_last;
   logic              ptr_exhausted;

   assign rd_addr       = ADDR_W'(sample_idx) * ADDR_W'(MN) + ADDR_W'(elem_ptr);
   assign last_sample   = (int'(sample_idx) == NUM_SAMPLES - 1);
   // A chunk ends on a full slot set or on the sample's final element, whichever comes first.
   assign chunk_last    = (int'(slot) == MAX_ELEMENTS - 1) || (int'(elem_ptr) == MN - 1);
   assign ptr_exhausted = (int'(elem_ptr) == MN);

   assign ready    = (state == PRESENT);
   assign all_done = (state == FINISH);
   assign busy     = (state == FILL) || (state == PRESENT) || (state == WAIT);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = FILL;
         FILL:    if (chunk_last) state_nx = PRESENT;
         PRESENT: state_nx = WAIT;
         WAIT: begin
            if (done)
               state_nx = last_sample ? FINISH : FILL;
            else if (data_request && !ptr_exhausted)
               state_nx = FILL;
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         sample_idx         <= '0;
         elem_ptr           <= '0;
         slot               <= '0;
         training_data      <= '0;
         training_data_type <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  sample_idx         <= '0;
                  elem_ptr           <= '0;
                  slot               <= '0;
                  training_data_type <= type_mem[0];
               end
            end
            FILL: begin
               training_data[int'(slot)*W +: W] <= elem_mem[rd_addr];
               elem_ptr <= elem_ptr + PTR_W'(1);
               slot     <= slot + SLOT_W'(1);
            end
            WAIT: begin
               if (done) begin
                  if (!last_sample) begin
                     sample_idx         <= sample_idx + IDX_W'(1);
                     training_data_type <= type_mem[sample_idx + IDX_W'(1)];
                     elem_ptr           <= '0;
                     slot               <= '0;
                  end
               end else if (data_request && !ptr_exhausted) begin
                  slot <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Sample and label memories have no reset so their contents survive rst.
   always_ff @(posedge clk) begin
      if (state == IDLE && wr_en)
         elem_mem[wr_addr] <= wr_data;
      if (state == IDLE && type_wr_en)
         type_mem[type_wr_addr] <= type_wr_data;
   end

`ifdef FEEDER_PROTOCOL_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         protocol_err <= 1'b0;
      else if (state == WAIT && data_request && (done || ptr_exhausted))
         protocol_err <= 1'b1;
   end
`else
   assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_training_data_feeder.sv
// Scoreboard bench for training_data_feeder: default-size instance plus a 3x3 / 4-element
// instance for the partial-chunk case.
module tb_training_data_feeder;
   localparam int W = 16;
`ifdef FEEDER_PROTOCOL_CHECK_EN
   localparam logic PE_EXP = 1'b1;
`else
   localparam logic PE_EXP = 1'b0;
`endif

   logic         clk = 1'b0, rst = 1'b0;
   logic         start = 1'b0, wr_en = 1'b0, type_wr_en = 1'b0, data_request = 1'b0, done = 1'b0;
   logic [5:0]   wr_addr = '0;
   logic [15:0]  wr_data = '0;
   logic [1:0]   type_wr_addr = '0, type_wr_data = '0;
   logic [255:0] training_data;
   logic [1:0]   training_data_type, sample_idx;
   logic         ready, busy, all_done, protocol_err;

   logic         start3 = 1'b0, wr_en3 = 1'b0, type_wr_en3 = 1'b0, data_request3 = 1'b0, done3 = 1'b0;
   logic [3:0]   wr_addr3 = '0;
   logic [15:0]  wr_data3 = '0;
   logic [0:0]   type_wr_addr3 = '0, sample_idx3;
   logic [1:0]   type_wr_data3 = '0, type3;
   logic [143:0] td3;
   logic         ready3, busy3, all_done3, perr3;

   training_data_feeder dut (
      .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .type_wr_en(type_wr_en), .type_wr_addr(type_wr_addr), .type_wr_data(type_wr_data),
      .data_request(data_request), .done(done), .training_data(training_data),
      .training_data_type(training_data_type), .ready(ready), .sample_idx(sample_idx),
      .busy(busy), .all_done(all_done), .protocol_err(protocol_err));

   training_data_feeder #(.M(3), .N(3), .W(16), .MAX_ELEMENTS(4), .TYPE_W(2), .NUM_SAMPLES(1)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
      .type_wr_en(type_wr_en3), .type_wr_addr(type_wr_addr3), .type_wr_data(type_wr_data3),
      .data_request(data_request3), .done(done3), .training_data(td3),
      .training_data_type(type3), .ready(ready3), .sample_idx(sample_idx3),
      .busy(busy3), .all_done(all_done3), .protocol_err(perr3));

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] td;
      logic [1:0]   typ;
      logic [1:0]   idx;
   } exp_t;

   exp_t         sbq[$];
   exp_t         e_mon;
   logic [15:0]  mdl_mem [4][16];
   logic [1:0]   mdl_type [4];
   logic [255:0] exp_td;
   logic [143:0] exp3;
   int           total = 0, bad = 0, ready_cnt = 0, alldone_cnt = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input int st, input int len);
      for (int j = 0; j < len; j++) exp_td[j*W +: W] = mdl_mem[s][st+j];
      sbq.push_back('{td: exp_td, typ: mdl_type[s], idx: 2'(s)});
   endtask

   task automatic drive_and_wait(input logic s_st, input logic s_rq, input logic s_dn,
                                 input int lat, input string tag);
      int n;
      start = s_st; data_request = s_rq; done = s_dn;
      tick();
      start = 1'b0; data_request = 1'b0; done = 1'b0;
      n = 1;
      while (ready !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, 256'(ready), 256'(1'b1));
      chk({tag, "_latency"}, 256'(n), 256'(lat));
      tick();
      chk({tag, "_pulse"}, 256'(ready), 256'(1'b0));
   endtask

   task automatic wait3(input logic s_st, input logic s_rq, input int lat, input string tag);
      int n;
      start3 = s_st; data_request3 = s_rq;
      tick();
      start3 = 1'b0; data_request3 = 1'b0;
      n = 1;
      while (ready3 !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, 256'(ready3), 256'(1'b1));
      chk({tag, "_latency"}, 256'(n), 256'(lat));
      chk({tag, "_data"}, 256'(td3), 256'(exp3));
      tick();
   endtask

   task automatic finish_pass(input string tag);
      chk({tag, "_type_at_done"}, 256'(training_data_type), 256'(mdl_type[3]));
      done = 1'b1;
      tick();
      done = 1'b0;
      chk({tag, "_all_done"}, 256'(all_done), 256'(1'b1));
      chk({tag, "_busy_off"}, 256'(busy), 256'(1'b0));
      tick();
      chk({tag, "_all_done_pulse"}, 256'(all_done), 256'(1'b0));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_td"}, training_data, '0);
      chk({tag, "_type"}, 256'(training_data_type), '0);
      chk({tag, "_ready"}, 256'(ready), '0);
      chk({tag, "_idx"}, 256'(sample_idx), '0);
      chk({tag, "_busy"}, 256'(busy), '0);
      chk({tag, "_all_done"}, 256'(all_done), '0);
      chk({tag, "_perr"}, 256'(protocol_err), '0);
   endtask

   always @(negedge clk) begin
      if (ready === 1'b1) begin
         ready_cnt++;
         if (sbq.size() == 0) begin
            chk("unexpected_ready", 256'(ready), 256'(1'b0));
         end else begin
            e_mon = sbq.pop_front();
            chk("chunk_data", training_data, e_mon.td);
            chk("chunk_type", 256'(training_data_type), 256'(e_mon.typ));
            chk("chunk_idx", 256'(sample_idx), 256'(e_mon.idx));
         end
      end
      if (all_done === 1'b1) alldone_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_td = '0;
      mdl_type = '{2'd2, 2'd1, 2'd3, 2'd0};
      #1 rst = 1'b1;
      #1 chk_reset("reset");
      tick();
      rst = 1'b0;

      for (int s = 0; s < 4; s++)
         for (int e = 0; e < 16; e++) begin
            mdl_mem[s][e] = 16'(s*16 + e + 1);
            wr_en = 1'b1; wr_addr = 6'(s*16 + e); wr_data = mdl_mem[s][e];
            tick();
         end
      wr_en = 1'b0;
      for (int s = 0; s < 4; s++) begin
         type_wr_en = 1'b1; type_wr_addr = 2'(s); type_wr_data = mdl_type[s];
         tick();
      end
      type_wr_en = 1'b0;
      for (int e = 0; e < 9; e++) begin
         wr_en3 = 1'b1; wr_addr3 = 4'(e); wr_data3 = 16'(16'h100 + e);
         tick();
      end
      wr_en3 = 1'b0;
      type_wr_en3 = 1'b1; type_wr_data3 = 2'd1;
      tick();
      type_wr_en3 = 1'b0;

      // Pass A: two chunks per sample, stray request after the final chunk.
      ready_cnt = 0; alldone_cnt = 0;
      push(0, 0, 8);
      drive_and_wait(1'b1, 1'b0, 1'b0, 9, "startA");
      for (int s = 0; s < 4; s++) begin
         chk("A_idx", 256'(sample_idx), 256'(s));
         push(s, 8, 8);
         drive_and_wait(1'b0, 1'b1, 1'b0, 9, "reqA");
         if (s < 3) begin
            chk("A_type_at_done", 256'(training_data_type), 256'(mdl_type[s]));
            push(s + 1, 0, 8);
            drive_and_wait(1'b0, 1'b0, 1'b1, 9, "doneA");
         end
      end
      data_request = 1'b1;
      tick();
      data_request = 1'b0;
      repeat (3) tick();
      chk("stray_no_ready", 256'(ready), 256'(1'b0));
      chk("stray_busy", 256'(busy), 256'(1'b1));
      chk("stray_perr", 256'(protocol_err), 256'(PE_EXP));
      finish_pass("A");
      repeat (2) tick();
      chk("A_ready_count", 256'(ready_cnt), 256'(8));
      chk("A_alldone_count", 256'(alldone_cnt), 256'(1));

      // Asynchronous reset in the middle of FILL.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("fill_busy", 256'(busy), 256'(1'b1));
      #2 rst = 1'b1;
      #1 chk_reset("midfill_rst");
      sbq.delete();
      exp_td = '0;
      tick();
      rst = 1'b0;

      // Pass B: start right after release, writes while busy, done+request together.
      push(0, 0, 8);
      drive_and_wait(1'b1, 1'b0, 1'b0, 9, "start_after_rst");
      wr_en = 1'b1; wr_addr = '0; wr_data = 16'hDEAD;
      type_wr_en = 1'b1; type_wr_addr = '0; type_wr_data = 2'd3;
      tick();
      wr_en = 1'b0; type_wr_en = 1'b0;
      push(1, 0, 8);
      drive_and_wait(1'b0, 1'b1, 1'b1, 9, "both");
      chk("both_idx", 256'(sample_idx), 256'(1));
      chk("both_perr", 256'(protocol_err), 256'(PE_EXP));
      for (int s = 1; s < 3; s++) begin
         push(s + 1, 0, 8);
         drive_and_wait(1'b0, 1'b0, 1'b1, 9, "doneB");
      end
      finish_pass("B");
      tick();

      // Pass C: memories still hold the original contents.
      push(0, 0, 8);
      drive_and_wait(1'b1, 1'b0, 1'b0, 9, "startC");
      for (int s = 0; s < 3; s++) begin
         push(s + 1, 0, 8);
         drive_and_wait(1'b0, 1'b0, 1'b1, 9, "doneC");
      end
      finish_pass("C");

      // Partial chunk: 9 elements in chunks of 4, 4, 1; last chunk keeps stale slots 1..3.
      exp3 = '0;
      for (int j = 0; j < 4; j++) exp3[j*16 +: 16] = 16'(16'h100 + j);
      wait3(1'b1, 1'b0, 5, "p_chunk0");
      chk("p_type", 256'(type3), 256'(2'd1));
      for (int j = 0; j < 4; j++) exp3[j*16 +: 16] = 16'(16'h104 + j);
      wait3(1'b0, 1'b1, 5, "p_chunk1");
      exp3[15:0] = 16'h108;
      wait3(1'b0, 1'b1, 2, "p_chunk2");
      done3 = 1'b1;
      tick();
      done3 = 1'b0;
      chk("p_all_done", 256'(all_done3), 256'(1'b1));
      tick();
      chk("p_idle", 256'(busy3), 256'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/training_data_feeder.md
# training_data_feeder

Supplies training samples to the KNN distance calculator, one chunk of up to MAX_ELEMENTS elements at a time, acting as the responder to the calculator's ready/data_request/done protocol. Holds NUM_SAMPLES samples of M*N W-bit elements plus a TYPE_W-bit class label each, preloaded through a write port. On start it presents every sample in order and signals completion after the calculator's final done.

## Interface

- M, 4: sample rows
- N, 4: sample columns
- W, 16: element width
- MAX_ELEMENTS, 8: elements per chunk; must be ≤ M*N
- TYPE_W, 2: label width
- NUM_SAMPLES, 4: stored samples; must be ≥ 1
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a pass; honoured only in IDLE
- wr_en  in  1  element write; honoured only in IDLE
- wr_addr  in  $clog2(NUM_SAMPLES*M*N)  global element index, sample*M*N + element
- wr_data  in  W  element value
- type_wr_en  in  1  label write; honoured only in IDLE
- type_wr_addr  in  $clog2(NUM_SAMPLES) (min 1)  sample index
- type_wr_data  in  TYPE_W  label value
- data_request  in  1  calculator asks for the next chunk
- done  in  1  calculator finished the current sample
- training_data  out  W*M*N  chunk; slot j occupies bits [(j+1)*W-1 -: W]
- training_data_type  out  TYPE_W  label of the current sample
- ready  out  1  one-cycle pulse: chunk valid
- sample_idx  out  $clog2(NUM_SAMPLES) (min 1)  current sample
- busy  out  1  pass in progress
- all_done  out  1  one-cycle pulse after the last sample
- protocol_err  out  1  sticky protocol violation flag

## Operation

- States: IDLE, FILL, PRESENT, WAIT, FINISH.
- IDLE: writes update the memories. Start sets busy=1, sample_idx=0, elem_ptr=0 and slot=0, loads training_data_type from label memory, then moves to FILL.
- FILL: each cycle copies element elem_ptr of the current sample into slot `slot`, then increments both. Chunk length is min(MAX_ELEMENTS, M*N - elem_ptr at chunk start). After the last element of the chunk, moves to PRESENT.
- FILL leaves slots beyond the chunk length holding stale data. Bits above MAX_ELEMENTS*W stay 0.
- PRESENT: ready=1 for exactly one cycle, then WAIT.
- WAIT: training_data and training_data_type are held stable.
  - done: on the last sample, go to FINISH. Otherwise increment sample_idx, load the new label, clear elem_ptr and slot, and go to FILL.
  - data_request with elem_ptr < M*N: clear slot and go to FILL.
  - data_request with elem_ptr = M*N: protocol violation. Stay in WAIT.
  - done and data_request together: done wins, and protocol_err is set.
- FINISH: all_done=1 for one cycle, busy=0, then IDLE.
- start, wr_en and type_wr_en outside IDLE are ignored.
- Memories are not reset. Their contents survive rst.

## Timing

- Reset values: training_data=0, training_data_type=0, ready=0, sample_idx=0, busy=0, all_done=0, protocol_err=0. State is IDLE.
- Reset mid-operation aborts immediately. A new start is accepted on the first cycle after rst deasserts.
- Start accepted at cycle t: FILL runs t+1 through t+L (L = chunk length), and ready is high at t+L+1.
- data_request or done seen at cycle t: next ready at t+L+1. This leaves at least two cycles of slack against the calculator's DONE→IDLE path.
- The label changes only on the cycle after done is seen, so the label is still valid in the same cycle as done.
- A write and start in the same IDLE cycle: the write is committed and start is also accepted. That element is read no earlier than t+1.

## Configuration

- FEEDER_PROTOCOL_CHECK_EN defined: protocol_err is set by a data_request with no remaining elements, or by done and data_request together. It clears only on rst.
- FEEDER_PROTOCOL_CHECK_EN undefined: protocol_err is tied to 0 and no check logic is built. Stray requests are still ignored, and done still wins.

## Test plan

- Reset: assert rst asynchronously mid-FILL → all outputs 0 immediately. A start after release produces ready 9 cycles later (defaults).
- Single sample, defaults, elements 1..16, label 2: start → training_data[127:0] holds 1..8 (element 1 in slot 0) with type 2 and one ready pulse. data_request → slots hold 9..16 and ready pulses. done → all_done pulse, busy=0.
- Four samples with a behavioural calculator model: sample_idx steps 0,1,2,3 with labels matching type memory. There are eight ready pulses and exactly one all_done, after the fourth done.
- Partial chunk, M=N=3, MAX_ELEMENTS=4: chunk lengths are 4, 4, 1. The last FILL lasts 1 cycle with slot 0 = element 8, and ready follows 2 cycles after data_request.
- Protocol: data_request after the final chunk → protocol_err=1 with the macro defined (0 without it), state stays WAIT, and a following done completes normally.
- Writes while busy are ignored: after the pass, memory read-back through a new pass shows the original values.
